pc_gen_btb: RTL and testbench
=============================

Name: pc_gen_btb

Overview:
Parametrised next-generation fetch PC unit with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Generates the fetch PC every cycle from: execute-stage redirect, stall hold, BTB prediction, or sequential pc+1.
- Trained by resolved-branch updates from execute.
- Adds tagged entries, configurable depth/width, allocate-on-taken policy and a mispredict performance counter.

Parameters:
ADDR_W, 10, instruction-memory word-address width (pc granularity is one word).
BTB_ENTRIES, 16, BTB depth; power of 2, at least 2; IDX_W = log2(BTB_ENTRIES); TAG_W = ADDR_W - IDX_W.
START_UP, 0, pc value loaded on reset.
PERF_W, 32, width of the mispredict counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  global enable; 0 freezes pc, BTB and counter
stall  in  1  hold pc (pipeline stall)
redirect  in  1  execute-stage mispredict/jump correction
redirect_addr  in  ADDR_W  corrected fetch address
upd_valid  in  1  resolved branch/jump update this cycle
upd_pc  in  ADDR_W  pc of the resolved branch
upd_target  in  ADDR_W  resolved target
upd_taken  in  1  resolved direction
pc  out  ADDR_W  current fetch pc (registered)
pc_4  out  ADDR_W  pc+1 modulo 2^ADDR_W (combinational)
pred_hit  out  1  BTB tag hit for current pc (combinational)
pred_taken  out  1  predicted taken for current pc (combinational)
mispredict_count  out  PERF_W  count of accepted redirects (registered)

Behaviour:
- Reset (rst=1 at a clock edge, overrides en):
  - pc <= START_UP.
  - All BTB valid bits cleared.
  - mispredict_count <= 0.
  - Target, tag and counter storage is not reset.
  - Reset while an update is presented: the update is discarded.
- Lookup (combinational, on the current pc):
  - idx = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
  - pred_hit = valid[idx] && tag_mem[idx]==tag.
  - pred_taken = pred_hit && cnt[idx][1].
  - Prediction always reads the pre-edge array contents; a same-cycle update to the same index is not bypassed.
- Next-pc priority, evaluated only when en=1 (en=0 holds pc):
  1. redirect=1: pc <= redirect_addr.
  2. Otherwise, stall=1: pc holds.
  3. Otherwise: pc <= pred_taken ? tgt_mem[idx] : pc_4.
- redirect has priority over stall.
- Latency: a redirect is visible on pc one cycle later. A BTB update affects predictions from the next cycle.
- Update, when en=1 and upd_valid=1 (independent of stall and redirect; may coincide with either):
  - Let u_idx and u_tag be taken from upd_pc in the same way as the lookup idx and tag.
  - Hit (valid and tag match):
    - cnt saturating +1 if upd_taken, -1 otherwise (range 00..11).
    - tgt_mem <= upd_target if upd_taken.
  - Miss and upd_taken=1: allocate, overwriting any alias.
    - valid <= 1, tag <= u_tag, tgt <= upd_target, cnt <= 2'b10 (weakly taken).
  - Miss and upd_taken=0: no change.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- mispredict_count increments by 1 on each cycle with en=1 and redirect=1. It wraps modulo 2^PERF_W.
- Arithmetic: pc_4 and all addresses wrap modulo 2^ADDR_W (pc=all-ones → 0).

Decomposition:
- Shared package pc_pkg holds:
  - ADDR_W default and START_UP.
  - Counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST and CNT_INIT=CNT_WT.
  - A function for the saturating counter update.
- One sub-module, btb_array, holds the valid/tag/target/counter storage, the lookup port and the update port (BTB_ENTRIES, ADDR_W parameters).
- pc_gen_btb holds the pc register, next-pc mux and perf counter.

Test Plan:
- Test 1 (reset and sequential fetch): ADDR_W=10, BTB_ENTRIES=16, START_UP=0.
  - rst=1 for 1 cycle → pc=0x000, pred_hit=0, mispredict_count=0.
  - Then en=1, no other inputs → pc 0x001, 0x002, 0x003 on successive cycles.
- Test 2 (allocate on taken): upd_valid=1, upd_pc=0x005, upd_target=0x040, upd_taken=1.
  - Later, when pc=0x005 → pred_hit=1, pred_taken=1, next pc=0x040.
- Test 3 (counter training): two not-taken updates on 0x005.
  - After the first, counter=01, pred_taken=0 at pc=0x005, next pc=0x006.
  - After the second, counter=00.
  - One taken update → 01, still not taken.
- Test 4 (priority): redirect=1, redirect_addr=0x100, stall=1, and a BTB hit at the current pc, all at once.
  - Next pc=0x100, mispredict_count=1.
  - stall=1 alone → pc holds at 0x100.
- Test 5 (alias replacement): taken update upd_pc=0x015 (same idx 5, tag 1), target 0x080.
  - At pc=0x005 → pred_hit=0, next pc=0x006.
  - At pc=0x015 → next pc=0x080.
- Test 6 (wrap and enable): pc=0x3FF, no hit → next pc=0x000.
  - en=0 with redirect=1 and upd_valid=1 → pc, BTB and mispredict_count are all unchanged.
  - rst=1 together with en=0 → pc=0x000 and BTB invalidated.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC generator and its branch target buffer.
// Contents:
//   PC_ADDR_W, PC_START_UP : default address width and reset pc
//   cnt_e                  : 2-bit direction-counter encoding
//   CNT_INIT               : counter value given to a freshly allocated entry
//   cnt_update()           : saturating counter step toward the resolved direction
package pc_pkg;

  localparam int PC_ADDR_W   = 10;
  localparam int PC_START_UP = 0;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strongly not taken
    CNT_WNT = 2'b01,  // weakly not taken
    CNT_WT  = 2'b10,  // weakly taken
    CNT_ST  = 2'b11   // strongly taken
  } cnt_e;

  localparam cnt_e CNT_INIT = CNT_WT;

  // Moves one step toward the resolved direction, holding at either end.
  function automatic cnt_e cnt_update(input cnt_e cur, input logic taken);
    cnt_e nxt;
    nxt = cur;
    case (cur)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears valid bits only)
//   en                : global enable; 0 blocks every update
//   lkp_pc            : pc to look up (combinational read of pre-edge contents)
//   lkp_hit/taken     : tag hit, and hit with counter in a taken state
//   lkp_target        : stored target for the looked-up index
//   upd_valid/pc/target/taken : resolved-branch training port
module btb_array
  import pc_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int ADDR_W      = PC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] lkp_pc,
  output logic              lkp_hit,
  output logic              lkp_taken,
  output logic [ADDR_W-1:0] lkp_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];
  cnt_e                   cnt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;

  assign l_idx = lkp_pc[IDX_W-1:0];
  assign l_tag = lkp_pc[ADDR_W-1:IDX_W];
  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W];

  // Lookup reads the arrays as they stand before the edge; no update bypass.
  assign lkp_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign lkp_taken  = lkp_hit && cnt_q[l_idx][1];
  assign lkp_target = tgt_q[l_idx];

  logic upd_en, u_hit, alloc, cnt_we, tgt_we;
  cnt_e cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    upd_en = 1'b0;
    u_hit  = 1'b0;
    alloc  = 1'b0;
    cnt_we = 1'b0;
    tgt_we = 1'b0;
    cnt_d  = cnt_q[u_idx];
    // A reset cycle discards any update presented alongside it.
    upd_en = en && upd_valid && !rst;
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // Allocate only on a taken miss; any alias at that index is replaced.
    alloc  = upd_en && !u_hit && upd_taken;
    cnt_we = alloc || (upd_en && u_hit);
    tgt_we = upd_en && upd_taken;
    cnt_d  = alloc ? CNT_INIT : cnt_update(cnt_q[u_idx], upd_taken);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // NOTE: tag, target and counter storage has no reset; the cleared valid
  // bits make stale contents unobservable, and the arrays stay plain RAM.
  always_ff @(posedge clk) begin
    if (cnt_we) cnt_q[u_idx] <= cnt_d;
    if (tgt_we) tgt_q[u_idx] <= upd_target;
    if (alloc)  tag_q[u_idx] <= u_tag;
  end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch-PC generator with an integrated BTB predictor.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (overrides en)
//   en                  : global enable; 0 freezes pc, BTB and counter
//   stall               : hold pc
//   redirect/_addr      : execute-stage correction, highest priority
//   upd_*               : resolved-branch training, independent of stall/redirect
//   pc                  : registered fetch pc
//   pc_4                : pc+1, wrapping
//   pred_hit/pred_taken : BTB prediction for the current pc
//   mispredict_count    : number of accepted redirects, wrapping
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W,
  parameter int BTB_ENTRIES = 16,
  parameter int START_UP    = PC_START_UP,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PERF_W-1:0] mispredict_count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic [ADDR_W-1:0] pred_target;

  btb_array #(
    .BTB_ENTRIES(BTB_ENTRIES),
    .ADDR_W     (ADDR_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lkp_pc    (pc_q),
    .lkp_hit   (pred_hit),
    .lkp_taken (pred_taken),
    .lkp_target(pred_target),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_target(upd_target),
    .upd_taken (upd_taken)
  );

  // Width-limited add gives the modulo-2^ADDR_W wrap for free.
  assign pc_4 = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d   = pc_q;
    perf_d = perf_q;
    if (en) begin
      if (redirect) begin
        pc_d   = redirect_addr;
        perf_d = perf_q + PERF_W'(1);
      end else if (!stall) begin
        pc_d = pred_taken ? pred_target : pc_4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= ADDR_W'(START_UP);
      perf_q <= '0;
    end else begin
      pc_q   <= pc_d;
      perf_q <= perf_d;
    end
  end

  assign pc               = pc_q;
  assign mispredict_count = perf_q;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Scoreboard bench for pc_gen_btb: the driver pushes the outputs expected for
// the current cycle from an arithmetic reference model; a monitor pops and
// compares them on the falling edge.
module tb_pc_gen_btb;

  localparam int ADDR_W   = 10;
  localparam int N        = 16;
  localparam int START_UP = 0;
  localparam int PERF_W   = 32;
  localparam int AMOD     = 1 << ADDR_W;

  logic              clk;
  logic              rst, en, stall, redirect, upd_valid, upd_taken;
  logic [ADDR_W-1:0] redirect_addr, upd_pc, upd_target;
  logic [ADDR_W-1:0] pc, pc_4;
  logic              pred_hit, pred_taken;
  logic [PERF_W-1:0] mispredict_count;

  pc_gen_btb #(
    .ADDR_W(ADDR_W), .BTB_ENTRIES(N), .START_UP(START_UP), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken),
    .pc(pc), .pc_4(pc_4), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    int unsigned pc4;
    bit          hit;
    bit          tk;
    int unsigned perf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a table of entries addressed by pc mod N, tagged by pc / N.
  int unsigned m_pc;
  int unsigned m_perf;
  bit          m_v   [N];
  int unsigned m_tag [N];
  int unsigned m_tgt [N];
  int unsigned m_cnt [N];
  bit          known = 1'b0;

  int unsigned pool [8] = '{'h005, 'h015, 'h025, 'h3FF, 'h010, 'h020, 'h100, 'h0FE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs of the current
  // state, advance the model across the coming edge, then wait for it.
  task automatic step(input bit r, input bit e, input bit st, input bit rd,
                      input int unsigned ra, input bit uv, input int unsigned up,
                      input int unsigned ut, input bit utk);
    exp_t        x;
    int unsigned i, t, ui, utg, pc4;
    bit          hit, tk;
    rst = r; en = e; stall = st; redirect = rd;
    redirect_addr = ADDR_W'(ra);
    upd_valid = uv; upd_pc = ADDR_W'(up); upd_target = ADDR_W'(ut); upd_taken = utk;

    i   = m_pc % N;
    t   = m_pc / N;
    pc4 = (m_pc + 1) % AMOD;
    hit = m_v[i] && (m_tag[i] == t);
    tk  = hit && (m_cnt[i] >= 2);
    if (known) begin
      x.pc = m_pc; x.pc4 = pc4; x.hit = hit; x.tk = tk; x.perf = m_perf;
      sb_q.push_back(x);
    end

    if (r) begin
      m_pc = START_UP;
      m_perf = 0;
      for (int k = 0; k < N; k++) m_v[k] = 1'b0;
    end else if (e) begin
      if (rd) begin
        m_pc = ra % AMOD;
        m_perf = m_perf + 1;
      end else if (!st) begin
        m_pc = tk ? m_tgt[i] : pc4;
      end
      if (uv) begin
        ui  = (up % AMOD) % N;
        utg = (up % AMOD) / N;
        if (m_v[ui] && m_tag[ui] == utg) begin
          if (utk) begin
            if (m_cnt[ui] < 3) m_cnt[ui] = m_cnt[ui] + 1;
            m_tgt[ui] = ut % AMOD;
          end else if (m_cnt[ui] > 0) begin
            m_cnt[ui] = m_cnt[ui] - 1;
          end
        end else if (utk) begin
          m_v[ui] = 1'b1; m_tag[ui] = utg; m_tgt[ui] = ut % AMOD; m_cnt[ui] = 2;
        end
      end
    end
    known = known || r;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the queued expectation against the DUT every falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("pc",               32'(pc),          x.pc);
        check("pc_4",             32'(pc_4),        x.pc4);
        check("pred_hit",         32'(pred_hit),    32'(x.hit));
        check("pred_taken",       32'(pred_taken),  32'(x.tk));
        check("mispredict_count", mispredict_count, x.perf);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    m_pc = 0; m_perf = 0;
    for (int k = 0; k < N; k++) begin
      m_v[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0;
    end
    @(posedge clk); #1;

    // Reset, then sequential fetch 0,1,2,3.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop(); nop();
    // Allocate 0x005 -> 0x040 while pc=3; pc 4, 5 (hit, taken), 0x040.
    step(0, 1, 0, 0, 0, 1, 'h005, 'h040, 1);
    nop(); nop(); nop();
    // Counter training: NT (10->01) with redirect to 5; pc 5 not taken -> 6.
    step(0, 1, 0, 1, 'h005, 1, 'h005, 'h000, 0);
    nop(); nop();
    step(0, 1, 0, 0, 0, 1, 'h005, 'h000, 0);           // 01 -> 00
    step(0, 1, 0, 1, 'h005, 1, 'h005, 'h040, 1);       // 00 -> 01, back to 5
    nop();
    // Priority: redirect beats stall and a BTB hit; then stall alone holds.
    step(0, 1, 0, 1, 'h005, 0, 0, 0, 0);
    step(0, 1, 1, 1, 'h100, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    nop();
    // Alias replacement: 0x015 evicts 0x005 at index 5.
    step(0, 1, 0, 1, 'h005, 1, 'h015, 'h080, 1);
    nop();
    step(0, 1, 0, 1, 'h015, 0, 0, 0, 0);
    nop(); nop();
    // Wrap at 0x3FF, enable freeze, reset with en=0.
    step(0, 1, 0, 1, 'h3FF, 0, 0, 0, 0);
    nop(); nop();
    step(0, 0, 0, 1, 'h200, 1, 'h000, 'h010, 1);
    nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h015, 0, 0, 0, 0);
    nop(); nop();

    // Randomized traffic concentrated on a few aliasing addresses.
    for (int c = 0; c < 1500; c++) begin
      bit          r, e, st, rd, uv, utk;
      int unsigned ra, up, ut;
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 5) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, AMOD - 1) : pool[$urandom_range(0, 7)];
      uv  = $urandom_range(0, 1);
      up  = ($urandom_range(0, 1) == 1) ? m_pc : pool[$urandom_range(0, 7)];
      ut  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, AMOD - 1) : pool[$urandom_range(0, 7)];
      utk = $urandom_range(0, 1);
      step(r, e, st, rd, ra, uv, up, ut, utk);
    end

    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    check("scoreboard_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
